// File: rtl/maze_game_ctrl_if.sv
// Signal bundle between the maze game controller and its host: control pulses,
// wall map, and the registered game status outputs.
interface maze_game_ctrl_if;
    logic         start;
    logic         btn_up;
    logic         btn_down;
    logic         btn_left;
    logic         btn_right;
    logic         frame_tick;
    logic [197:0] mazestate;
    logic [7:0]   player_tile;
    logic [7:0]   counter;
    logic [2:0]   cp_progress;
    logic [2:0]   lives;
    logic [2:0]   game_state;
    logic [15:0]  elapsed;

    modport master (
        output start, btn_up, btn_down, btn_left, btn_right, frame_tick, mazestate,
        input  player_tile, counter, cp_progress, lives, game_state, elapsed
    );

    modport slave (
        input  start, btn_up, btn_down, btn_left, btn_right, frame_tick, mazestate,
        output player_tile, counter, cp_progress, lives, game_state, elapsed
    );
endinterface

// File: rtl/maze_game_ctrl.sv
// Game sequencer for the 18x11 OLED maze: player moves against the wall map,
// hit flash, in-order checkpoints, lives, and win/lose.
module maze_game_ctrl #(
    parameter int START_TILE   = 19,
    parameter int FLASH_FRAMES = 30,
    parameter int LIVES        = 3
) (
    input  logic             CLK,
    input  logic             RST,
    maze_game_ctrl_if.slave  bus
);

    localparam logic [4:0] START_COL = 5'(START_TILE % 18);
    localparam logic [3:0] START_ROW = 4'(START_TILE / 18);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CHECK = 3'd2,
        S_HIT   = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    function automatic logic [7:0] tile_of(input logic [4:0] c, input logic [3:0] r);
        return 8'(c) + 8'(r) * 8'd18;
    endfunction

    function automatic logic [7:0] next_cp(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'd31;
            3'd1:    return 8'd37;
            3'd2:    return 8'd113;
            3'd3:    return 8'd139;
            3'd4:    return 8'd178;
            default: return 8'hFF;
        endcase
    endfunction

    state_t      r_state,     w_state;
    logic [4:0]  r_col,       w_col;
    logic [3:0]  r_row,       w_row;
    logic [4:0]  r_cand_col,  w_cand_col;
    logic [3:0]  r_cand_row,  w_cand_row;
    logic [4:0]  r_resp_col,  w_resp_col;
    logic [3:0]  r_resp_row,  w_resp_row;
    logic [7:0]  r_flash_cnt, w_flash_cnt;
    logic [7:0]  r_counter,   w_counter;
    logic [2:0]  r_cp,        w_cp;
    logic [2:0]  r_lives,     w_lives;
    logic [15:0] r_elapsed,   w_elapsed;
    logic [7:0]  r_tile,      w_tile;
    logic [7:0]  w_cand_idx;

    assign w_cand_idx = tile_of(r_cand_col, r_cand_row);
    assign w_tile     = tile_of(w_col, w_row);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_col       <= START_COL;
            r_row       <= START_ROW;
            r_cand_col  <= START_COL;
            r_cand_row  <= START_ROW;
            r_resp_col  <= START_COL;
            r_resp_row  <= START_ROW;
            r_flash_cnt <= '0;
            r_counter   <= '0;
            r_cp        <= '0;
            r_lives     <= 3'(LIVES);
            r_elapsed   <= '0;
            r_tile      <= 8'(START_TILE);
        end else begin
            r_state     <= w_state;
            r_col       <= w_col;
            r_row       <= w_row;
            r_cand_col  <= w_cand_col;
            r_cand_row  <= w_cand_row;
            r_resp_col  <= w_resp_col;
            r_resp_row  <= w_resp_row;
            r_flash_cnt <= w_flash_cnt;
            r_counter   <= w_counter;
            r_cp        <= w_cp;
            r_lives     <= w_lives;
            r_elapsed   <= w_elapsed;
            r_tile      <= w_tile;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_col       = r_col;
        w_row       = r_row;
        w_cand_col  = r_cand_col;
        w_cand_row  = r_cand_row;
        w_resp_col  = r_resp_col;
        w_resp_row  = r_resp_row;
        w_flash_cnt = r_flash_cnt;
        w_counter   = r_counter;
        w_cp        = r_cp;
        w_lives     = r_lives;
        w_elapsed   = r_elapsed;

        if (bus.frame_tick && (r_state == S_PLAY || r_state == S_CHECK || r_state == S_HIT)
            && r_elapsed != 16'hFFFF)
            w_elapsed = r_elapsed + 16'd1;

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start) begin
                    w_state     = S_PLAY;
                    w_col       = START_COL;
                    w_row       = START_ROW;
                    w_resp_col  = START_COL;
                    w_resp_row  = START_ROW;
                    w_cp        = '0;
                    w_lives     = 3'(LIVES);
                    w_elapsed   = '0;
                    w_counter   = '0;
                    w_flash_cnt = '0;
                end
            end
            S_PLAY: begin
                // Priority up > down > left > right; an off-grid winner cancels the move.
                if (bus.btn_up) begin
                    if (r_row != 4'd0) begin
                        w_cand_col = r_col;
                        w_cand_row = r_row - 4'd1;
                        w_state    = S_CHECK;
                    end
                end else if (bus.btn_down) begin
                    if (r_row != 4'd10) begin
                        w_cand_col = r_col;
                        w_cand_row = r_row + 4'd1;
                        w_state    = S_CHECK;
                    end
                end else if (bus.btn_left) begin
                    if (r_col != 5'd0) begin
                        w_cand_col = r_col - 5'd1;
                        w_cand_row = r_row;
                        w_state    = S_CHECK;
                    end
                end else if (bus.btn_right) begin
                    if (r_col != 5'd17) begin
                        w_cand_col = r_col + 5'd1;
                        w_cand_row = r_row;
                        w_state    = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (bus.mazestate[w_cand_idx]) begin
                    w_col   = r_cand_col;
                    w_row   = r_cand_row;
                    w_state = S_PLAY;
                    if (w_cand_idx == next_cp(r_cp)) begin
                        w_cp       = r_cp + 3'd1;
                        w_resp_col = r_cand_col;
                        w_resp_row = r_cand_row;
                        if (r_cp == 3'd4)
                            w_state = S_WIN;
                    end
                end else begin
                    w_counter   = 8'd255;
                    w_lives     = r_lives - 3'd1;
                    w_flash_cnt = 8'(FLASH_FRAMES);
                    w_state     = S_HIT;
                end
            end
            S_HIT: begin
                if (bus.frame_tick) begin
                    w_flash_cnt = r_flash_cnt - 8'd1;
                    if (r_flash_cnt == 8'd1) begin
                        w_col = r_resp_col;
                        w_row = r_resp_row;
                        if (r_lives == 3'd0) begin
                            w_state = S_LOSE;
                        end else begin
                            w_counter = '0;
                            w_state   = S_PLAY;
                        end
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.player_tile = r_tile;
    assign bus.counter     = r_counter;
    assign bus.cp_progress = r_cp;
    assign bus.lives       = r_lives;
    assign bus.game_state  = r_state;
    assign bus.elapsed     = r_elapsed;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Scoreboard bench for maze_game_ctrl: a small game model predicts each move,
// flash and restart outcome, which is queued and compared against the outputs.
module tb_maze_game_ctrl;

    localparam int FLASH = 30;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_CHECK = 2, ST_HIT = 3, ST_WIN = 4, ST_LOSE = 5;

    logic clk_sys;
    logic rst;
    maze_game_ctrl_if bus();

    maze_game_ctrl #(.START_TILE(19), .FLASH_FRAMES(FLASH), .LIVES(3)) dut (
        .CLK (clk_sys),
        .RST (rst),
        .bus (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int tile;
        int cnt;
        int cp;
        int lives;
        int st;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [197:0] maze;
    int cps[5] = '{31, 37, 113, 139, 178};
    int m_col, m_row, m_resp_col, m_resp_row, m_cp, m_lives, m_state, m_elapsed;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.tile  = m_col + 18 * m_row;
        e.cnt   = (m_state == ST_HIT || m_state == ST_LOSE) ? 255 : 0;
        e.cp    = m_cp;
        e.lives = m_lives;
        e.st    = m_state;
        sb_q.push_back(e);
    endtask

    task automatic cmp_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".tile"},  int'(bus.player_tile), e.tile);
            chk({tag, ".cnt"},   int'(bus.counter),     e.cnt);
            chk({tag, ".cp"},    int'(bus.cp_progress), e.cp);
            chk({tag, ".lives"}, int'(bus.lives),       e.lives);
            chk({tag, ".state"}, int'(bus.game_state),  e.st);
        end
    endtask

    task automatic model_restart();
        m_col = 1; m_row = 1; m_resp_col = 1; m_resp_row = 1;
        m_cp = 0; m_lives = 3; m_state = ST_PLAY; m_elapsed = 0;
    endtask

    task automatic do_start(input string tag);
        if (m_state == ST_IDLE || m_state == ST_WIN || m_state == ST_LOSE)
            model_restart();
        push_exp();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cmp_out(tag);
    endtask

    // Model of one button pulse (with priority), then two edges to the result.
    task automatic press(input string tag, input logic u, input logic d, input logic l, input logic r);
        int nc, nr, cand;
        bit ok;
        nc = m_col; nr = m_row; ok = 1'b1;
        if (m_state != ST_PLAY)   ok = 1'b0;
        else if (u) begin if (m_row == 0)  ok = 1'b0; else nr = m_row - 1; end
        else if (d) begin if (m_row == 10) ok = 1'b0; else nr = m_row + 1; end
        else if (l) begin if (m_col == 0)  ok = 1'b0; else nc = m_col - 1; end
        else if (r) begin if (m_col == 17) ok = 1'b0; else nc = m_col + 1; end
        else ok = 1'b0;
        if (ok) begin
            cand = nc + 18 * nr;
            if (maze[cand]) begin
                m_col = nc; m_row = nr;
                if (m_cp < 5 && cand == cps[m_cp]) begin
                    m_cp++;
                    m_resp_col = nc; m_resp_row = nr;
                end
                m_state = (m_cp == 5) ? ST_WIN : ST_PLAY;
            end else begin
                m_lives--;
                m_state = ST_HIT;
            end
        end
        push_exp();
        bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
        bus.mazestate = maze;
        tick();
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
        tick();
        cmp_out(tag);
    endtask

    task automatic run_flash(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            bus.frame_tick = 1'b1;
            tick();
            bus.frame_tick = 1'b0;
            m_elapsed++;
            if (k == FLASH - 1) begin
                chk({tag, ".pre_exit_state"}, int'(bus.game_state), ST_HIT);
                chk({tag, ".pre_exit_cnt"},   int'(bus.counter),    255);
            end
            tick();
        end
        if (n == FLASH) begin
            m_col = m_resp_col; m_row = m_resp_row;
            m_state = (m_lives == 0) ? ST_LOSE : ST_PLAY;
            push_exp();
            cmp_out(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.frame_tick = 1'b0;
        maze = '0;
        maze[19] = 1'b1;
        bus.mazestate = maze;
        model_restart();
        m_state = ST_IDLE;

        repeat (3) tick();
        push_exp();
        cmp_out("reset");
        chk("reset.elapsed", int'(bus.elapsed), 0);
        rst = 1'b0;
        tick();

        do_start("start1");

        press("wall20", 1'b0, 1'b0, 1'b0, 1'b1);
        run_flash("flash1", FLASH);

        for (int i = 20; i <= 31; i++) maze[i] = 1'b1;
        for (int i = 0; i < 12; i++) press("walk_right", 1'b0, 1'b0, 1'b0, 1'b1);

        maze[41] = 1'b1; maze[59] = 1'b1; maze[77] = 1'b1; maze[95] = 1'b1; maze[113] = 1'b1;
        for (int i = 0; i < 8; i++) press("walk_left", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) press("walk_down_113", 1'b0, 1'b1, 1'b0, 1'b0);

        press("wall131", 1'b0, 1'b1, 1'b0, 1'b0);
        run_flash("flash2_resp31", FLASH);

        maze[18] = 1'b1; maze[0] = 1'b1;
        for (int i = 0; i < 13; i++) press("walk_col0", 1'b0, 1'b0, 1'b1, 1'b0);
        press("edge_left", 1'b0, 1'b0, 1'b1, 1'b0);
        press("prio_up_right", 1'b1, 1'b0, 1'b0, 1'b1);
        press("edge_up", 1'b1, 1'b0, 1'b0, 1'b0);

        press("wall1", 1'b0, 1'b0, 1'b0, 1'b1);
        run_flash("flash3_lose", FLASH);
        chk("lose.elapsed", int'(bus.elapsed), m_elapsed);
        press("btn_in_lose", 1'b0, 1'b0, 1'b0, 1'b1);

        do_start("restart");
        chk("restart.elapsed", int'(bus.elapsed), 0);

        // Second pulse lands in CHECK and must be dropped.
        m_col = 2;
        push_exp();
        push_exp();
        bus.btn_right = 1'b1;
        tick();
        tick();
        bus.btn_right = 1'b0;
        cmp_out("drop_in_check");
        tick(); tick();
        cmp_out("drop_in_check_after");

        press("wall38", 1'b0, 1'b1, 1'b0, 1'b0);
        run_flash("partial_flash", FLASH - 12);
        #2 rst = 1'b1;
        #1;
        model_restart();
        m_state = ST_IDLE;
        push_exp();
        cmp_out("rst_mid_flash");
        chk("rst_mid_flash.elapsed", int'(bus.elapsed), 0);
        tick();
        rst = 1'b0;
        push_exp();
        for (int i = 0; i < 15; i++) begin
            bus.frame_tick = 1'b1;
            tick();
            bus.frame_tick = 1'b0;
        end
        cmp_out("idle_after_rst");
        chk("idle_after_rst.elapsed", int'(bus.elapsed), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
